// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state encoding,
// button bit positions and a small helper for sizing the shared counter.
package btn_pkg;

    typedef enum logic [6:0] {
        ST_IDLE        = 7'b000_0001,
        ST_PRESS_CHK   = 7'b000_0010,
        ST_SCEN        = 7'b000_0100,
        ST_HOLD        = 7'b000_1000,
        ST_MCEN        = 7'b001_0000,
        ST_REPEAT      = 7'b010_0000,
        ST_RELEASE_CHK = 7'b100_0000
    } btn_state_e;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce/auto-repeat FSM and its counter.
// All outputs are decoded from the state register only.
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic dpb_o,
    output logic scen_o,
    output logic mcen_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q;
    logic             s_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            s_q     <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns state_d and cnt_inc; no latches.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_q) state_d = ST_PRESS_CHK;
            end
            ST_PRESS_CHK: begin
                if (!s_q)                 state_d = ST_IDLE;
                else if (cnt_q == DEB_LAST) state_d = ST_SCEN;
                else                      cnt_inc = 1'b1;
            end
            ST_SCEN: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!s_q)                 state_d = ST_RELEASE_CHK;
                else if (cnt_q == DLY_LAST) state_d = ST_MCEN;
                else                      cnt_inc = 1'b1;
            end
            ST_MCEN: state_d = ST_REPEAT;
            ST_REPEAT: begin
                if (!s_q)                 state_d = ST_RELEASE_CHK;
                else if (cnt_q == PER_LAST) state_d = ST_MCEN;
                else                      cnt_inc = 1'b1;
            end
            ST_RELEASE_CHK: begin
                if (s_q)                  state_d = ST_HOLD;
                else if (cnt_q == DEB_LAST) state_d = ST_IDLE;
                else                      cnt_inc = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counting only happens while a state is kept, so any transition clears it.
    assign cnt_d = cnt_inc ? cnt_q + 1'b1 : '0;

    assign dpb_o  = (state_q != ST_IDLE) && (state_q != ST_PRESS_CHK);
    assign scen_o = (state_q == ST_SCEN);
    assign mcen_o = (state_q == ST_SCEN) || (state_q == ST_MCEN);

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels turning raw push-buttons into debounced
// levels, single-cycle press enables and auto-repeat enables.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] DPBs,
    output logic [NUM_BTNS-1:0] SCENs,
    output logic [NUM_BTNS-1:0] MCENs
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_in[i]),
            .dpb_o  (DPBs[i]),
            .scen_o (SCENs[i]),
            .mcen_o (MCENs[i])
        );
    end

endmodule
